// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding and default sizing for the memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 15;
    localparam int TMO_CNT_W   = 8;

endpackage

// File: rtl/mem_ctrl_tmo.sv
// Wait-state counter for the memory controller; flags the last allowed WAIT cycle.
// Only instantiated when MEM_CTRL_TIMEOUT_EN is defined.
module mem_ctrl_tmo
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [TMO_CNT_W-1:0] cnt_r;

    // Count WAIT cycles without acknowledge; restart on every new access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The count holds k-1 during the k-th WAIT cycle.
    assign last = (cnt_r == TMO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_ctrl.sv
// Single-access memory controller: IDLE -> WAIT (until ack) -> DONE, all outputs registered.
// Optional ack timeout enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              MEM_CTRL_clk,
    input  logic              MEM_CTRL_rst,
    input  logic              MEM_CTRL_req,
    input  logic              MEM_CTRL_we,
    input  logic [ADDR_W-1:0] MEM_CTRL_addr,
    input  logic [DATA_W-1:0] MEM_CTRL_wdata,
    output logic [DATA_W-1:0] MEM_CTRL_rdata,
    output logic              MEM_CTRL_busy,
    output logic              MEM_CTRL_done,
    output logic              MEM_CTRL_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t            state_r;
    logic [DATA_W-1:0] rdata_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              tmo_s;

`ifdef MEM_CTRL_TIMEOUT_EN
    logic tmo_last_s;

    mem_ctrl_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk  (MEM_CTRL_clk),
        .rst  (MEM_CTRL_rst),
        .clr  ((state_r == ST_IDLE) && MEM_CTRL_req),
        .inc  ((state_r == ST_WAIT) && !mem_ack),
        .last (tmo_last_s)
    );

    assign tmo_s = (state_r == ST_WAIT) && tmo_last_s;
`else
    assign tmo_s = 1'b0;
`endif

    // Access sequencer; ack is checked before timeout so a late ack still succeeds.
    always_ff @(posedge MEM_CTRL_clk or posedge MEM_CTRL_rst) begin
        if (MEM_CTRL_rst) begin
            state_r     <= ST_IDLE;
            rdata_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (MEM_CTRL_req) begin
                        state_r     <= ST_WAIT;
                        busy_r      <= 1'b1;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= MEM_CTRL_we;
                        mem_addr_r  <= MEM_CTRL_addr;
                        mem_wdata_r <= MEM_CTRL_wdata;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        if (!mem_we_r) begin
                            rdata_r <= mem_rdata;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        state_r  <= ST_DONE;
                        done_r   <= 1'b1;
                        err_r    <= 1'b0;
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                    end else if (tmo_s) begin
                        state_r  <= ST_DONE;
                        done_r   <= 1'b1;
                        err_r    <= 1'b1;
                        mem_en_r <= 1'b0;
                        mem_we_r <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    err_r    <= 1'b0;
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_CTRL_rdata = rdata_r;
    assign MEM_CTRL_busy  = busy_r;
    assign MEM_CTRL_done  = done_r;
    assign MEM_CTRL_err   = err_r;
    assign mem_en         = mem_en_r;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;

endmodule
